// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: sequencer for a free-running serial shift register.
// Accepts a WIDTH-bit word over valid/ready, shifts it MSB-first onto sr_in,
// samples sr_out after DEPTH edges of pipeline latency, rebuilds the word on
// dout with a one-cycle dout_valid pulse and raises a sticky err on any
// loopback mismatch.
//
// Ports:
//   clk        rising-edge clock, shared with the shift register
//   clr        asynchronous active-low reset, shared with the shift register
//   din_valid  producer has a word on din
//   din        word to send, sampled only on accept
//   ready      controller can accept a word (registered)
//   busy       transfer in progress: SHIFT, WAIT or DONE (registered)
//   sr_in      serial bit to the shift register input (registered)
//   sr_out     serial bit from the shift register output
//   dout       last received word, held until the next completion (registered)
//   dout_valid one-cycle pulse when dout updates (registered)
//   err        sticky loopback mismatch flag (registered)
//   err_clr    synchronous clear of err; a same-edge mismatch wins
module shiftreg_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             sr_in,
    input  logic             sr_out,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             err,
    input  logic             err_clr
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + WIDTH + 2);
    localparam int unsigned LAST_TX  = WIDTH;
    localparam int unsigned FIRST_RX = DEPTH + 1;
    localparam int unsigned LAST_RX  = DEPTH + WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic [WIDTH-1:0]   rx_q, rx_d;

    logic               ready_d;
    logic               busy_d;
    logic               sr_in_d;
    logic [WIDTH-1:0]   dout_d;
    logic               dout_valid_d;
    logic               err_d;

    logic [WIDTH-1:0]   tx_shl;
    logic [WIDTH-1:0]   rx_shift;
    logic               sample;
    logic               last;

    // Bit k of the transfer (MSB first) is the top bit of tx shifted left by k.
    assign tx_shl   = tx_q << cnt_q;
    // Receive word with this edge's sr_out sample appended at the LSB.
    assign rx_shift = WIDTH'({rx_q, sr_out});
    // Sampling window is set by the edge count alone, so it may overlap SHIFT.
    assign sample   = (cnt_q >= CNT_W'(FIRST_RX));
    assign last     = (cnt_q == CNT_W'(LAST_RX));

    // State, counter, data and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            sr_in      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            ready      <= ready_d;
            busy       <= busy_d;
            sr_in      <= sr_in_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            err        <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        ready_d      = ready;
        busy_d       = busy;
        sr_in_d      = 1'b0;
        dout_d       = dout;
        dout_valid_d = 1'b0;
        err_d        = err;

        // Clear first so a mismatch detected on the same edge overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (din_valid && ready) begin
                    tx_d    = din;
                    rx_d    = '0;
                    sr_in_d = din[WIDTH-1];
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end

            SHIFT, WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sample) begin
                    rx_d = rx_shift;
                end
                if (state_q == SHIFT) begin
                    if (cnt_q < CNT_W'(LAST_TX)) begin
                        sr_in_d = tx_shl[WIDTH-1];
                    end else begin
                        state_d = WAIT;
                    end
                end
                if (last) begin
                    dout_d       = rx_shift;
                    dout_valid_d = 1'b1;
                    state_d      = DONE;
                    if (rx_shift != tx_q) begin
                        err_d = 1'b1;
                    end
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Bench for shiftreg_ctrl with a behavioural DEPTH-stage shift register on
// the serial loop and a stuck-at-1 fault injector on sr_out.
module tb_shiftreg_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             err;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] din;
        bit               stuck;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             clr;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             busy;
    logic             sr_in;
    logic             sr_out;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             err;
    logic             err_clr;
    bit               stuck;

    logic [DEPTH-1:0] sreg;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    shiftreg_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clr        (clr),
        .din_valid  (din_valid),
        .din        (din),
        .ready      (ready),
        .busy       (busy),
        .sr_in      (sr_in),
        .sr_out     (sr_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .err        (err),
        .err_clr    (err_clr)
    );

    // Free-running shift register, no enable, shares clk/clr with the DUT.
    always @(posedge clk or negedge clr) begin
        if (!clr) sreg <= '0;
        else      sreg <= {sreg[DEPTH-2:0], sr_in};
    end
    assign sr_out = stuck ? 1'b1 : sreg[DEPTH-1];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk4(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Scoreboard consumer: every dout_valid pulse must match the oldest push.
    always @(posedge clk) begin
        #1;
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected dout_valid: dout=%b with no word outstanding at %0t", dout, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk4("sb dout", dout, e.dout);
                chk1("sb err", err, e.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] ed, input logic ee);
        exp_t e;
        e.dout = ed;
        e.err  = ee;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int i = 0;
        while (ready !== 1'b1 && i < 40) begin
            step();
            i++;
        end
        if (ready !== 1'b1) begin
            n_total++;
            $display("FAIL ready timeout: ready=%b expected 1", ready);
        end
    endtask

    // Offer a word and return just after its accept edge (edge 0).
    task automatic send(input logic [WIDTH-1:0] word, input bit stk,
                        input logic [WIDTH-1:0] ed, input logic ee);
        din_valid = 1'b1;
        din       = word;
        stuck     = stk;
        wait_ready();
        push_exp(ed, ee);
        step();
        din_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (sb.size() != 0 && i < 60) begin
            step();
            i++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL dout_valid timeout: %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        stuck = 1'b0;
        step();
    endtask

    task automatic pulse_clr_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk1("err after err_clr", err, 1'b0);
    endtask

    // Cycle-exact walk through one transfer, starting just after edge 0.
    // With junk set, din_valid stays high and din wanders mid-transfer.
    task automatic check_transfer(input logic [WIDTH-1:0] word, input bit junk);
        logic [WIDTH-1:0] sh;
        for (int k = 1; k <= DEPTH + WIDTH + 1; k++) begin
            if (junk && k <= DEPTH + WIDTH) begin
                din_valid = 1'b1;
                din       = (k == 1) ? 4'b1111 : WIDTH'($urandom);
            end
            step();
            sh = word << k;
            chk1("sr_in", sr_in, (k < WIDTH) ? sh[WIDTH-1] : 1'b0);
            chk1("dout_valid timing", dout_valid, k == DEPTH + WIDTH);
            chk1("ready timing", ready, k == DEPTH + WIDTH + 1);
            chk1("busy timing", busy, k <= DEPTH + WIDTH);
        end
        chk4("dout hold", dout, word);
        din_valid = 1'b0;
        step();
        chk1("no extra accept busy", busy, 1'b0);
        chk1("no extra accept ready", ready, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " ready"}, ready, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " sr_in"}, sr_in, 1'b0);
        chk4({tag, " dout"}, dout, '0);
        chk1({tag, " dout_valid"}, dout_valid, 1'b0);
        chk1({tag, " err"}, err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{4'b1111, 1'b1, 4'b1111, 1'b0};
        vecs[1] = '{4'b1100, 1'b0, 4'b1100, 1'b0};
        vecs[2] = '{4'b1010, 1'b0, 4'b1010, 1'b0};
        vecs[3] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
        vecs[4] = '{4'b0000, 1'b1, 4'b1111, 1'b1};
        vecs[5] = '{4'b0110, 1'b0, 4'b0110, 1'b1};
        vecs[6] = '{4'b1000, 1'b1, 4'b1111, 1'b1};

        clr       = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        err_clr   = 1'b0;
        stuck     = 1'b0;

        // Reset held across edges, then release.
        #1;
        chk_all_zero("reset");
        repeat (3) step();
        chk_all_zero("reset held");
        clr = 1'b1;
        step();
        chk1("ready after release", ready, 1'b1);
        chk1("sr_in idle", sr_in, 1'b0);
        repeat (2) step();
        chk1("sr_in idle later", sr_in, 1'b0);
        chk1("busy idle", busy, 1'b0);

        // Single word with cycle-exact timing.
        send(4'b1100, 1'b0, 4'b1100, 1'b0);
        chk1("sr_in edge0", sr_in, 1'b1);
        chk1("busy edge0", busy, 1'b1);
        chk1("ready edge0", ready, 1'b0);
        check_transfer(4'b1100, 1'b0);

        // Back-to-back with din_valid held high.
        din_valid = 1'b1;
        din       = 4'b1010;
        wait_ready();
        push_exp(4'b1010, 1'b0);
        push_exp(4'b0101, 1'b0);
        step();
        din = 4'b0101;
        for (int k = 1; k <= DEPTH + WIDTH + 2; k++) begin
            step();
            chk1("b2b dout_valid", dout_valid, k == DEPTH + WIDTH);
            chk1("b2b ready", ready, k == DEPTH + WIDTH + 1);
            chk1("b2b busy", busy, k != DEPTH + WIDTH + 1);
        end
        chk1("b2b second sr_in msb", sr_in, 1'b0);
        din_valid = 1'b0;
        wait_done();
        chk1("b2b err", err, 1'b0);

        // Table of transfers, including stuck-at-1 faults and sticky err.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].din, vecs[i].stuck, vecs[i].exp_dout, vecs[i].exp_err);
            wait_done();
            chk1("table err", err, vecs[i].exp_err);
            chk4("table dout", dout, vecs[i].exp_dout);
        end

        // Sticky err across a good transfer, clear, then clear vs mismatch.
        pulse_clr_err();
        send(4'b0000, 1'b1, 4'b1111, 1'b1);
        wait_done();
        chk1("fault err set", err, 1'b1);
        send(4'b1001, 1'b0, 4'b1001, 1'b1);
        wait_done();
        chk1("err sticky", err, 1'b1);
        pulse_clr_err();
        send(4'b0000, 1'b1, 4'b1111, 1'b1);
        repeat (DEPTH + WIDTH - 1) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk1("coincident dout_valid", dout_valid, 1'b1);
        chk1("coincident err set wins", err, 1'b1);
        wait_done();
        pulse_clr_err();

        // din_valid/din ignored during a transfer.
        send(4'b0110, 1'b0, 4'b0110, 1'b0);
        chk1("ignored sr_in edge0", sr_in, 1'b0);
        check_transfer(4'b0110, 1'b1);
        chkn("ignored queue drained", sb.size(), 0);

        // Reset between edges 5 and 6 of a transfer.
        send(4'b1100, 1'b0, 4'b1100, 1'b0);
        repeat (5) step();
        #2;
        clr = 1'b0;
        sb.delete();
        #1;
        chk_all_zero("mid reset");
        repeat (4) step();
        chk1("mid reset no dout_valid", dout_valid, 1'b0);
        chk1("mid reset ready held", ready, 1'b0);
        clr = 1'b1;
        send(4'b0011, 1'b0, 4'b0011, 1'b0);
        wait_done();
        chk4("after reset dout", dout, 4'b0011);
        chk1("after reset err", err, 1'b0);

        repeat (3) step();
        chkn("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
